mkgauss_ctrl: RTL and testbench
===============================

MKGAUSS_CTRL -- requirements
Module: mkgauss_ctrl

Interface
REQ-001 Parameter DEPTH, default 4, maximum number of Gaussian samples in flight plus buffered (credit pool and output FIFO depth, 2..16).
REQ-002 Ports, one per line as name  direction  width  meaning:
- clk  in  1  sole clock, rising edge;
- rst_n  in  1  asynchronous active-low reset;
- start  in  1  begin a batch;
- logn  in  4  batch size n = 2^logn;
- busy  out  1  batch in progress;
- done  out  1  one-cycle batch-complete pulse;
- err  out  1  sticky protocol-error flag.
REQ-003 Random-word input port: rnd_valid  in  1;  rnd  in  64;  rnd_ready  out  1.
REQ-004 Sampler-side ports: r1_valid  out  1;  r1  out  64;  r2_valid  out  1;  r2  out  64;  val_valid  in  1;  val  in  32 signed.
REQ-005 Sample-output ports: smp_valid  out  1;  smp  out  32 signed;  smp_idx  out  10;  smp_ready  in  1.

Function
REQ-006 FSM states: IDLE, RUN, DRAIN.
- IDLE -> RUN on start.
- RUN -> DRAIN when the n-th r2 has been issued.
- DRAIN -> IDLE on the n-th sample output transfer.
REQ-007 start is sampled only in IDLE; start in RUN/DRAIN is ignored, with no state change.
REQ-008 On accepted start:
- n = 2^min(logn,10); logn=0 gives n=1.
- Issue, receive and output counters clear to 0; credits = DEPTH; phase = 0.
REQ-009 busy = 1 in RUN and DRAIN, 0 in IDLE; it rises the cycle after accepted start.
REQ-010 rnd_ready = 1 only in RUN, when issued < n, and (phase = 1 or credits > 0).
- A word transfers on rnd_valid & rnd_ready.
REQ-011 Transfer with phase 0:
- Next cycle: r1 <= rnd, r1_valid = 1 for exactly one cycle.
- credits decrement; phase <= 1.
REQ-012 Transfer with phase 1:
- Next cycle: r2 <= rnd, r2_valid = 1 for exactly one cycle.
- issued increments; phase <= 0.
REQ-013 r1_valid and r2_valid are never high in the same cycle; r1/r2 hold their last values when not valid.
REQ-014 Every val_valid in RUN/DRAIN pushes val into the output FIFO (depth DEPTH) and increments received.
REQ-015 val_valid in IDLE, or with the FIFO full, is dropped and sets err.
REQ-016 err stays 1 until reset or the next accepted start.
REQ-017 FIFO output behaviour:
- smp_valid = FIFO non-empty; smp = FIFO head.
- smp_idx = output count (0..n-1).
- A transfer occurs on smp_valid & smp_ready; it pops the FIFO, increments the output count and returns one credit.
REQ-018 Simultaneous credit return and phase-0 word transfer leaves credits unchanged; credits never exceed DEPTH and never go below 0.
REQ-019 Simultaneous FIFO push and pop leaves occupancy unchanged and is legal when the FIFO is full.
REQ-020 done pulses 1 for one cycle, in the cycle after the n-th output transfer; the FSM is in IDLE that same cycle.
REQ-021 start may be accepted in the cycle done is high.
REQ-022 smp_valid/smp are stable while smp_valid & !smp_ready.
REQ-023 Latency:
- Word transfer to r1/r2 valid: 1 cycle.
- val_valid to smp_valid on an empty FIFO: 1 cycle.

Reset
REQ-024 rst_n low, asynchronous, forces:
- state IDLE, phase 0, credits DEPTH, all counters 0, FIFO empty;
- busy, done, err, rnd_ready, r1_valid, r2_valid, smp_valid = 0;
- r1, r2, smp, smp_idx = 0.
REQ-025 Reset asserted mid-batch discards all in-flight words and samples; no done follows.
REQ-026 Operation resumes on the first rising edge after rst_n deasserts, with a fresh start required.

Verification
REQ-027 Basic batch: logn=1, DEPTH=4, words A,B,C,D back-to-back, sampler returns 5 then -7, smp_ready=1 ->
- r1=A, r2=B, r1=C, r2=D pulses;
- smp=5 with idx 0, then smp=-7 with idx 1;
- done one cycle after the second transfer.
REQ-028 Credit stall: logn=3, DEPTH=4, smp_ready=0, sampler returns each sample 3 cycles after r2 ->
- exactly 4 r1 pulses, then rnd_ready stays 0;
- after smp_ready=1 for one transfer, one further r1/r2 pair issues.
REQ-029 Simultaneous push/pop with full FIFO and credit return plus phase-0 transfer in the same cycle -> occupancy 4 and credits unchanged; err=0.
REQ-030 Protocol error: val_valid in IDLE -> err=1, no smp_valid; next accepted start clears err.
REQ-031 Mid-batch reset: rst_n low after 3 r2 pulses of a logn=2 batch -> all outputs 0 next cycle, busy=0, no done.
REQ-032 Clamp and ignore: start with logn=15 -> exactly 1024 samples, smp_idx reaches 1023; a second start while busy is ignored.

Source files
------------

// File: rtl/mkgauss_ctrl.sv
// mkgauss_ctrl: batch controller for a Gaussian sampler.
// Pairs incoming 64-bit random words into r1/r2 pulses for the sampler, collects the
// sampler's signed results in a DEPTH-entry FIFO and streams them out with an index.
// A credit pool of DEPTH bounds the samples in flight plus buffered, so the FIFO never
// overflows under correct sampler behaviour.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start, logn                begin a batch of n = 2^min(logn,10) samples
//   busy, done, err            batch active, completion pulse, sticky protocol error
//   rnd_valid/rnd/rnd_ready    random-word input handshake
//   r1_valid/r1, r2_valid/r2   one-cycle word pulses to the sampler
//   val_valid/val              sampler result
//   smp_valid/smp/smp_idx/smp_ready  sample output handshake
module mkgauss_ctrl #(
   parameter int unsigned DEPTH = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [3:0]         logn,
   output logic               busy,
   output logic               done,
   output logic               err,
   input  logic               rnd_valid,
   input  logic [63:0]        rnd,
   output logic               rnd_ready,
   output logic               r1_valid,
   output logic [63:0]        r1,
   output logic               r2_valid,
   output logic [63:0]        r2,
   input  logic               val_valid,
   input  logic signed [31:0] val,
   output logic               smp_valid,
   output logic signed [31:0] smp,
   output logic [9:0]         smp_idx,
   input  logic               smp_ready
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

   state_e          state_q, state_d;
   logic            phase_q, phase_d;
   logic [CW-1:0]   credits_q, credits_d;
   logic [10:0]     n_q, n_d;
   logic [10:0]     issued_q, issued_d;
   logic [10:0]     received_q, received_d;
   logic [9:0]      out_q, out_d;
   logic [63:0]     r1_q, r1_d, r2_q, r2_d;
   logic            r1_valid_q, r1_valid_d, r2_valid_q, r2_valid_d;
   logic            done_q, done_d, err_q, err_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic signed [31:0] mem [DEPTH];

   logic busy_st, word_xfer, pop, push, fifo_full, credit_ret, credit_take;

   assign busy_st   = (state_q != StIdle);
   assign rnd_ready = (state_q == StRun) && (issued_q < n_q) &&
                      (phase_q || (credits_q != '0));
   assign word_xfer = rnd_valid & rnd_ready;
   assign smp_valid = (count_q != '0);
   assign pop       = smp_valid & smp_ready;
   assign fifo_full = (count_q == CW'(DEPTH));
   // A full FIFO can still take a push when the head leaves in the same cycle.
   assign push      = val_valid & busy_st & (~fifo_full | pop);
   // Saturate so stray sampler results can never inflate the pool past DEPTH.
   assign credit_ret  = pop & (credits_q < CW'(DEPTH));
   assign credit_take = word_xfer & ~phase_q;

   always_comb begin
      state_d    = state_q;
      phase_d    = phase_q;
      credits_d  = credits_q;
      n_d        = n_q;
      issued_d   = issued_q;
      received_d = received_q;
      out_d      = out_q;
      r1_d       = r1_q;
      r2_d       = r2_q;
      r1_valid_d = 1'b0;
      r2_valid_d = 1'b0;
      done_d     = 1'b0;
      err_d      = err_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q + CW'(push) - CW'(pop);

      if (word_xfer) begin
         if (!phase_q) begin
            r1_d       = rnd;
            r1_valid_d = 1'b1;
            phase_d    = 1'b1;
         end else begin
            r2_d       = rnd;
            r2_valid_d = 1'b1;
            phase_d    = 1'b0;
            issued_d   = issued_q + 11'd1;
         end
      end

      if (credit_ret && !credit_take) begin
         credits_d = credits_q + CW'(1);
      end else if (!credit_ret && credit_take) begin
         credits_d = credits_q - CW'(1);
      end

      if (push) begin
         wr_ptr_d   = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
         received_d = received_q + 11'd1;
      end
      if (pop) begin
         rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
         out_d    = out_q + 10'd1;
      end
      if (val_valid && !push) begin
         err_d = 1'b1;
      end

      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d    = StRun;
               n_d        = (logn > 4'd9) ? 11'd1024 : (11'd1 << logn);
               phase_d    = 1'b0;
               credits_d  = CW'(DEPTH);
               issued_d   = '0;
               received_d = '0;
               out_d      = '0;
               err_d      = val_valid;
               // Leftover results from a misbehaving sampler must not leak into a new batch.
               wr_ptr_d   = '0;
               rd_ptr_d   = '0;
               count_d    = '0;
            end
         end
         StRun: begin
            if (word_xfer && phase_q && (issued_q + 11'd1 == n_q)) begin
               state_d = StDrain;
            end
         end
         StDrain: begin
            if (pop && (11'(out_q) + 11'd1 == n_q)) begin
               state_d = StIdle;
               done_d  = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         phase_q    <= 1'b0;
         credits_q  <= CW'(DEPTH);
         n_q        <= 11'd1;
         issued_q   <= '0;
         received_q <= '0;
         out_q      <= '0;
         r1_q       <= '0;
         r2_q       <= '0;
         r1_valid_q <= 1'b0;
         r2_valid_q <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         phase_q    <= phase_d;
         credits_q  <= credits_d;
         n_q        <= n_d;
         issued_q   <= issued_d;
         received_q <= received_d;
         out_q      <= out_d;
         r1_q       <= r1_d;
         r2_q       <= r2_d;
         r1_valid_q <= r1_valid_d;
         r2_valid_q <= r2_valid_d;
         done_q     <= done_d;
         err_q      <= err_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_q] <= val;
      end
   end

   assign busy     = busy_st;
   assign done     = done_q;
   assign err      = err_q;
   assign r1       = r1_q;
   assign r2       = r2_q;
   assign r1_valid = r1_valid_q;
   assign r2_valid = r2_valid_q;
   // Head is masked when empty so the output reads 0 after reset.
   assign smp      = smp_valid ? mem[rd_ptr_q] : '0;
   assign smp_idx  = out_q;

endmodule

// File: tb/tb_mkgauss_ctrl.sv
// Directed bench for mkgauss_ctrl (DEPTH = 4).
module tb_mkgauss_ctrl;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               start = 1'b0;
   logic [3:0]         logn = '0;
   logic               busy, done, err;
   logic               rnd_valid = 1'b0;
   logic [63:0]        rnd = '0;
   logic               rnd_ready;
   logic               r1_valid, r2_valid;
   logic [63:0]        r1, r2;
   logic               val_valid = 1'b0;
   logic signed [31:0] val = '0;
   logic               smp_valid;
   logic signed [31:0] smp;
   logic [9:0]         smp_idx;
   logic               smp_ready = 1'b0;

   int vectors = 0;
   int miscompares = 0;
   int r1c, r2c, pops, k, idx_bad, last_idx, done_cnt;
   logic [2:0] pipe;
   logic done_seen;

   mkgauss_ctrl #(.DEPTH(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .logn      (logn),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .rnd_valid (rnd_valid),
      .rnd       (rnd),
      .rnd_ready (rnd_ready),
      .r1_valid  (r1_valid),
      .r1        (r1),
      .r2_valid  (r2_valid),
      .r2        (r2),
      .val_valid (val_valid),
      .val       (val),
      .smp_valid (smp_valid),
      .smp       (smp),
      .smp_idx   (smp_idx),
      .smp_ready (smp_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      rnd_valid = 1'b0;
      val_valid = 1'b0;
      smp_ready = 1'b0;
      start     = 1'b0;
      rst_n     = 1'b0;
      tick();
      rst_n     = 1'b1;
   endtask

   initial begin
      // Reset state
      #12;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_rnd_ready", rnd_ready, 0);
      check("rst_r1_valid", r1_valid, 0);
      check("rst_r2_valid", r2_valid, 0);
      check("rst_smp_valid", smp_valid, 0);
      check("rst_r1", r1, 0);
      check("rst_r2", r2, 0);
      check("rst_smp", smp, 0);
      check("rst_smp_idx", smp_idx, 0);
      tick();
      rst_n = 1'b1;

      // Protocol error: result while idle
      val_valid = 1'b1;
      val = 99;
      tick();
      val_valid = 1'b0;
      check("idle_err", err, 1);
      check("idle_no_smp", smp_valid, 0);
      check("idle_busy", busy, 0);

      // Basic batch, logn=1
      smp_ready = 1'b1;
      logn = 4'd1;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("b_busy", busy, 1);
      check("b_err_cleared", err, 0);
      check("b_rnd_ready", rnd_ready, 1);
      rnd_valid = 1'b1;
      rnd = 64'hAAAA_0000_0000_000A;
      tick();
      check("b_r1v_A", r1_valid, 1);
      check("b_r1_A", r1, 64'hAAAA_0000_0000_000A);
      check("b_r2v_A", r2_valid, 0);
      rnd = 64'hBBBB_0000_0000_000B;
      tick();
      check("b_r2v_B", r2_valid, 1);
      check("b_r2_B", r2, 64'hBBBB_0000_0000_000B);
      check("b_r1v_B", r1_valid, 0);
      check("b_r1_hold", r1, 64'hAAAA_0000_0000_000A);
      rnd = 64'hCCCC_0000_0000_000C;
      tick();
      check("b_r1v_C", r1_valid, 1);
      check("b_r1_C", r1, 64'hCCCC_0000_0000_000C);
      rnd = 64'hDDDD_0000_0000_000D;
      tick();
      rnd_valid = 1'b0;
      check("b_r2v_D", r2_valid, 1);
      check("b_r2_D", r2, 64'hDDDD_0000_0000_000D);
      check("b_drain_rnd_ready", rnd_ready, 0);
      check("b_drain_busy", busy, 1);
      val_valid = 1'b1;
      val = 5;
      tick();
      check("b_smp0_valid", smp_valid, 1);
      check("b_smp0", smp, 5);
      check("b_idx0", smp_idx, 0);
      val = -7;
      tick();
      val_valid = 1'b0;
      check("b_smp1_valid", smp_valid, 1);
      check("b_smp1", smp, -7);
      check("b_idx1", smp_idx, 1);
      check("b_done_early", done, 0);
      tick();
      check("b_done", done, 1);
      check("b_busy_done", busy, 0);
      check("b_smp_empty", smp_valid, 0);
      tick();
      check("b_done_once", done, 0);

      // Credit stall, logn=3, results come back a few cycles after r2
      smp_ready = 1'b0;
      logn = 4'd3;
      start = 1'b1;
      tick();
      start = 1'b0;
      rnd_valid = 1'b1;
      pipe = '0;
      r1c = 0;
      for (int i = 0; i < 30; i++) begin
         rnd = 64'h1000 + 64'(i);
         r1c += int'(r1_valid);
         val_valid = pipe[2];
         val = i;
         pipe = {pipe[1:0], r2_valid};
         tick();
      end
      val_valid = 1'b0;
      check("cs_r1_pulses", r1c, 4);
      check("cs_rnd_ready_stall", rnd_ready, 0);
      check("cs_smp_valid", smp_valid, 1);
      check("cs_idx0", smp_idx, 0);
      check("cs_err", err, 0);
      smp_ready = 1'b1;
      tick();
      smp_ready = 1'b0;
      check("cs_idx1", smp_idx, 1);
      r1c = 0;
      r2c = 0;
      for (int i = 0; i < 15; i++) begin
         rnd = 64'h2000 + 64'(i);
         r1c += int'(r1_valid);
         r2c += int'(r2_valid);
         val_valid = pipe[2];
         val = i;
         pipe = {pipe[1:0], r2_valid};
         tick();
      end
      val_valid = 1'b0;
      check("cs_extra_r1", r1c, 1);
      check("cs_extra_r2", r2c, 1);
      check("cs_restall", rnd_ready, 0);
      check("cs_err_end", err, 0);
      pulse_reset();

      // Full FIFO push+pop with credit return and phase-0 transfer together
      logn = 4'd3;
      start = 1'b1;
      tick();
      start = 1'b0;
      rnd_valid = 1'b1;
      rnd = 64'd1;
      tick();
      rnd = 64'd2;
      tick();
      rnd_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         val_valid = 1'b1;
         val = 10 + i;
         tick();
      end
      val_valid = 1'b0;
      check("pp_full_valid", smp_valid, 1);
      check("pp_head", smp, 10);
      check("pp_rnd_ready", rnd_ready, 1);
      val_valid = 1'b1;
      val = 14;
      smp_ready = 1'b1;
      rnd_valid = 1'b1;
      rnd = 64'd3;
      tick();
      val_valid = 1'b0;
      smp_ready = 1'b0;
      rnd = 64'd4;
      check("pp_r1v", r1_valid, 1);
      check("pp_idx", smp_idx, 1);
      check("pp_head2", smp, 11);
      check("pp_err", err, 0);
      r1c = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         r1c += int'(r1_valid);
      end
      rnd_valid = 1'b0;
      check("pp_credits_kept", r1c, 3);
      check("pp_stall", rnd_ready, 0);
      smp_ready = 1'b1;
      pops = 0;
      for (int i = 0; i < 6; i++) begin
         if (smp_valid) begin
            check("pp_order", smp, 64'(11 + pops));
            pops++;
         end
         tick();
      end
      smp_ready = 1'b0;
      check("pp_occupancy", pops, 4);
      check("pp_err_end", err, 0);
      pulse_reset();

      // Mid-batch reset after three r2 pulses
      logn = 4'd2;
      start = 1'b1;
      tick();
      start = 1'b0;
      smp_ready = 1'b1;
      rnd_valid = 1'b1;
      r2c = 0;
      for (int i = 0; i < 40 && r2c < 3; i++) begin
         rnd = 64'hA5A5_0000_0000_0000 | 64'(i + 1);
         tick();
         r2c += int'(r2_valid);
      end
      check("mr_r2_count", r2c, 3);
      rst_n = 1'b0;
      #1;
      check("mr_busy", busy, 0);
      check("mr_rnd_ready", rnd_ready, 0);
      check("mr_r1_valid", r1_valid, 0);
      check("mr_r2_valid", r2_valid, 0);
      check("mr_r1", r1, 0);
      check("mr_r2", r2, 0);
      check("mr_smp_valid", smp_valid, 0);
      check("mr_smp_idx", smp_idx, 0);
      check("mr_done", done, 0);
      rnd_valid = 1'b0;
      tick();
      rst_n = 1'b1;
      done_seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (done) done_seen = 1'b1;
      end
      check("mr_no_done", done_seen, 0);
      check("mr_idle_busy", busy, 0);
      check("mr_needs_start", rnd_ready, 0);

      // Clamp logn=15 to 1024 samples; second start while busy is ignored
      smp_ready = 1'b1;
      logn = 4'd15;
      start = 1'b1;
      tick();
      start = 1'b0;
      logn = 4'd0;
      rnd_valid = 1'b1;
      r2c = 0;
      k = 0;
      idx_bad = 0;
      last_idx = -1;
      done_cnt = 0;
      for (int i = 0; i < 5000 && done_cnt == 0; i++) begin
         start = (i == 3);
         rnd = 64'(i);
         if (smp_valid) begin
            if (smp !== k || int'(smp_idx) != (k % 1024)) idx_bad++;
            last_idx = int'(smp_idx);
            k++;
         end
         val_valid = r2_valid;
         val = r2c;
         r2c += int'(r2_valid);
         tick();
         if (done) done_cnt++;
      end
      start = 1'b0;
      val_valid = 1'b0;
      rnd_valid = 1'b0;
      check("cl_done_seen", done_cnt, 1);
      check("cl_transfers", k, 1024);
      check("cl_r2_count", r2c, 1024);
      check("cl_last_idx", last_idx, 1023);
      check("cl_order_errors", idx_bad, 0);
      check("cl_busy_end", busy, 0);
      check("cl_err", err, 0);
      tick();
      check("cl_done_once", done, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
